// File: rtl/disp_pkg.sv
// Shared constants and request record for the disp_scan seven-segment driver.
package disp_pkg;

    localparam int unsigned MAX_DIGITS = 16;

    localparam logic [3:0] CODE_BLANK = 4'd0;
    localparam logic [3:0] CODE_ERR   = 4'd1;
    localparam logic [3:0] CODE_DASH  = 4'd2;
    localparam logic [3:0] CODE_OVF   = 4'd3;
    localparam logic [3:0] CODE_HI    = 4'd4;

    // Character selectors for seg_decode; 0..9 are the decimal digits themselves.
    localparam logic [4:0] CH_DASH  = 5'd10;
    localparam logic [4:0] CH_E     = 5'd11;
    localparam logic [4:0] CH_R     = 5'd12;
    localparam logic [4:0] CH_O     = 5'd13;
    localparam logic [4:0] CH_F     = 5'd14;
    localparam logic [4:0] CH_H     = 5'd15;
    localparam logic [4:0] CH_I     = 5'd16;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_I     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Sized for the largest panel; narrower builds zero-extend dp and num.
    typedef struct packed {
        logic        mode;
        logic [3:0]  dp;
        logic [3:0]  code;
        logic [63:0] num;
    } disp_req_t;

    localparam disp_req_t REQ_RESET = '{mode: 1'b1, dp: 4'd0, code: CODE_BLANK, num: 64'd0};

endpackage

// File: rtl/seg_decode.sv
// Combinational character to active-low seven-segment pattern decoder.
module seg_decode
    import disp_pkg::*;
(
    input  logic [4:0] ch,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (ch)
                5'd0:    seg = SEG_0;
                5'd1:    seg = SEG_1;
                5'd2:    seg = SEG_2;
                5'd3:    seg = SEG_3;
                5'd4:    seg = SEG_4;
                5'd5:    seg = SEG_5;
                5'd6:    seg = SEG_6;
                5'd7:    seg = SEG_7;
                5'd8:    seg = SEG_8;
                5'd9:    seg = SEG_9;
                CH_DASH: seg = SEG_DASH;
                CH_E:    seg = SEG_E;
                CH_R:    seg = SEG_R;
                CH_O:    seg = SEG_O;
                CH_F:    seg = SEG_F;
                CH_H:    seg = SEG_H;
                CH_I:    seg = SEG_I;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned double buffering.
// Optional blinking is enabled by defining DISP_BLINK_EN.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        mode,
    input  logic [$clog2(N_DIGITS)-1:0] dp,
    input  logic [3:0]                  code,
    input  logic [4*N_DIGITS-1:0]       num,
`ifdef DISP_BLINK_EN
    input  logic                        blink,
`endif
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  seg,
    output logic                        seg_dp,
    output logic                        frame_done,
    output logic                        pending
);

    localparam int unsigned IW = $clog2(N_DIGITS);
    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    disp_req_t     active, pend_buf, req_in;
    logic          tick, wrap, blank_all;

    assign tick   = (pre == PW'(PRESCALE - 1));
    assign wrap   = tick && (idx == IW'(N_DIGITS - 1));
    assign req_in = '{mode: mode, dp: 4'(dp), code: code, num: 64'(num)};

`ifdef DISP_BLINK_EN
    localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) frame_cnt <= '0;
        else if (wrap) frame_cnt <= frame_cnt + FW'(1);
    end

    assign blank_all = blink && frame_cnt[FW-1];
`else
    assign blank_all = 1'b0;
`endif

    // Decode of the digit currently selected by idx.
    logic [3:0] nib, idx_ext;
    logic       lead, blank_ch, dp_n;
    logic [4:0] ch;
    logic [6:0] seg_n;

    always_comb begin
        idx_ext  = 4'(idx);
        nib      = active.num[4*idx +: 4];
        lead     = 1'b1;
        ch       = CH_BLANK;
        blank_ch = 1'b0;
        dp_n     = 1'b1;
        // Any glyph-bearing nibble (1..9 or '-') above this digit stops zero blanking.
        for (int j = 0; j < int'(MAX_DIGITS); j++) begin
            if (j > int'(idx) && active.num[4*j +: 4] != 4'h0 && active.num[4*j +: 4] <= 4'hA)
                lead = 1'b0;
        end
        if (active.mode) begin
            case (active.code)
                CODE_ERR:  ch = (idx_ext == 4'd2) ? CH_E :
                                (idx_ext <= 4'd1) ? CH_R : CH_BLANK;
                CODE_DASH: ch = CH_DASH;
                CODE_OVF:  ch = (idx_ext == 4'd1) ? CH_O :
                                (idx_ext == 4'd0) ? CH_F : CH_BLANK;
                CODE_HI:   ch = (idx_ext == 4'd1) ? CH_H :
                                (idx_ext == 4'd0) ? CH_I : CH_BLANK;
                default:   ch = CH_BLANK;
            endcase
        end else begin
            ch       = (nib <= 4'hA) ? {1'b0, nib} : CH_BLANK;
            blank_ch = (nib == 4'h0) && lead && (idx_ext > active.dp);
            dp_n     = (idx_ext != active.dp);
        end
    end

    seg_decode u_seg_decode (
        .ch    (ch),
        .blank (blank_ch),
        .seg   (seg_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            idx        <= '0;
            active     <= REQ_RESET;
            pend_buf   <= REQ_RESET;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            seg_dp     <= 1'b1;
        end else begin
            pre        <= tick ? '0 : pre + PW'(1);
            if (tick) idx <= wrap ? '0 : idx + IW'(1);
            frame_done <= wrap;
            if (wrap) begin
                // A load on the commit cycle bypasses straight into the active buffer.
                if (load) active <= req_in;
                else if (pending) active <= pend_buf;
                if (load) pend_buf <= req_in;
                pending <= 1'b0;
            end else if (load) begin
                pend_buf <= req_in;
                pending  <= 1'b1;
            end
            an     <= blank_all ? '1 : ~(N_DIGITS'(1) << idx);
            seg    <= seg_n;
            seg_dp <= dp_n;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: a frame-level reference model queues expected outputs per cycle.
module tb_disp_scan;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int BF = 1;
    localparam int FR = N * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  dp = 2'd0;
    logic [3:0]  code = 4'd0;
    logic [15:0] num = 16'd0;
`ifdef DISP_BLINK_EN
    logic        blink = 1'b1;
`endif
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        seg_dp, frame_done, pending;

    always #5 clk = ~clk;

    disp_scan #(.N_DIGITS(N), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .mode       (mode),
        .dp         (dp),
        .code       (code),
        .num        (num),
`ifdef DISP_BLINK_EN
        .blink      (blink),
`endif
        .an         (an),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    typedef struct {
        bit          mode;
        int          dp;
        int          code;
        logic [15:0] num;
    } req_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       sdp;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: k = clock edges since the last reset edge.
    int   k = 0;
    int   fc = 0;
    req_t act, pnd;
    bit   pnd_v = 0;

    function automatic logic [6:0] glyph(byte c);
        case (c)
            "0": return 7'h3F;  "1": return 7'h06;  "2": return 7'h5B;  "3": return 7'h4F;
            "4": return 7'h66;  "5": return 7'h6D;  "6": return 7'h7D;  "7": return 7'h07;
            "8": return 7'h7F;  "9": return 7'h6F;  "-": return 7'h40;  "E": return 7'h79;
            "r": return 7'h50;  "O": return 7'h3F;  "F": return 7'h71;  "H": return 7'h76;
            "I": return 7'h06;
            default: return 7'h00;
        endcase
    endfunction

    // Returns {seg_dp, seg} (active-low) for digit d of request r.
    function automatic logic [7:0] render(req_t r, int d);
        byte   c;
        string msg;
        int    ms, n;
        bit    pt;
        c = " ";
        pt = 0;
        if (r.mode) begin
            case (r.code)
                1: msg = "Err";
                3: msg = "OF";
                4: msg = "HI";
                default: msg = "";
            endcase
            if (r.code == 2) c = "-";
            else if (d < msg.len()) c = msg[msg.len() - 1 - d];
        end else begin
            ms = -1;
            for (int i = 0; i < N; i++) begin
                n = int'(r.num[4*i +: 4]);
                if (n >= 1 && n <= 10) ms = i;
            end
            n = int'(r.num[4*d +: 4]);
            if (n <= 9) c = byte'(48 + n);
            else if (n == 10) c = "-";
            if (n == 0 && d > r.dp && d > ms) c = " ";
            pt = (d == r.dp);
        end
        return {~pt, ~glyph(c)};
    endfunction

    function automatic req_t blank_req();
        req_t r;
        r.mode = 1; r.dp = 0; r.code = 0; r.num = '0;
        return r;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(bit r_v, bit l_v, bit m_v, int dp_v, int code_v, logic [15:0] num_v);
        exp_t e;
        req_t in;
        logic [7:0] g;
        int d;
        @(negedge clk);
        rst = r_v; load = l_v; mode = m_v; dp = 2'(dp_v); code = 4'(code_v); num = num_v;
        in.mode = m_v; in.dp = dp_v; in.code = code_v; in.num = num_v;
        if (r_v) begin
            e = '{an: 4'hF, seg: 7'h7F, sdp: 1'b1, fd: 1'b0, pend: 1'b0};
            k = 0; fc = 0; act = blank_req(); pnd = blank_req(); pnd_v = 0;
        end else begin
            d = (k % FR) / P;
            g = render(act, d);
            e.an  = ((fc % (2 * BF)) >= BF) ? 4'hF : ~(4'b1 << d);
`ifndef DISP_BLINK_EN
            e.an  = ~(4'b1 << d);
`endif
            e.seg = g[6:0];
            e.sdp = g[7];
            e.fd  = ((k + 1) % FR == 0);
            if (e.fd) begin
                if (l_v) act = in;
                else if (pnd_v) act = pnd;
                pnd_v = 0;
                fc++;
            end else if (l_v) begin
                pnd = in;
                pnd_v = 1;
            end
            e.pend = pnd_v;
            k++;
        end
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic ld(bit m_v, int dp_v, int code_v, logic [15:0] num_v);
        step(0, 1, m_v, dp_v, code_v, num_v);
    endtask

    // Idle until the next step lands on the commit edge.
    task automatic to_commit();
        while ((k + 1) % FR != 0) idle(1);
    endtask

    task automatic chk(string name, int act_v, int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act_v, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("an", int'(an), int'(e.an));
                chk("seg", int'(seg), int'(e.seg));
                chk("seg_dp", int'(seg_dp), int'(e.sdp));
                chk("frame_done", int'(frame_done), int'(e.fd));
                chk("pending", int'(pending), int'(e.pend));
            end
        end
    end

    initial begin : stim
        logic [15:0] rn;
        act = blank_req();
        pnd = blank_req();
        step(1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0);
        idle(8);
        idle(3);
        ld(0, 0, 0, 16'h0042);
        idle(12);
        ld(0, 2, 0, 16'h0005);
        idle(12);
        while (k % FR != 2) idle(1);
        ld(1, 0, 1, 16'h0);
        idle(2);
        ld(1, 0, 2, 16'h0);
        idle(12);
        to_commit();
        ld(1, 0, 4, 16'h0);
        idle(10);
        idle(3);
        ld(0, 1, 0, 16'h1234);
        idle(1);
        step(1, 0, 0, 0, 0, 16'h0);
        idle(12);
        for (int i = 0; i < 2000; i++) begin
            for (int j = 0; j < 4; j++)
                rn[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 299) == 0)
                step(1, 0, 0, 0, 0, 16'h0);
            else if ($urandom_range(0, 5) == 0)
                ld(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), rn);
            else
                idle(1);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
# disp_scan

- Parametrised, time-multiplexed seven-segment driver for the calculator front panel; next generation of the display block.
- Accepts a BCD number with a decimal-point position, or a canned message code, through a load strobe.
- Double-buffers the request and commits it only at a frame boundary, so the display never tears.
- Scans `N_DIGITS` common-anode digits with a programmable dwell time.

## Interface

Parameters:

- `N_DIGITS`, 8, number of digits scanned (2..16).
- `PRESCALE`, 1000, `clk` cycles each digit is lit (≥2).
- `BLINK_FRAMES`, 64, frames per blink half-period (only with `DISP_BLINK_EN`).

Ports:

- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe; captures `mode`, `dp`, `code`, `num` into the pending buffer.
- `mode` in 1: 0 = number, 1 = message code.
- `dp` in `$clog2(N_DIGITS)`: digit index carrying the decimal point; 0 = LSD.
- `code` in 4: message code, used when `mode=1`.
- `num` in `4*N_DIGITS`: BCD nibbles; nibble 0 = LSD.
- `blink` in 1: blank display on alternate half-periods (only with `DISP_BLINK_EN`).
- `an` out `N_DIGITS`: digit enables, active-low, one-hot-cold.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `seg_dp` out 1: decimal-point segment, active-low.
- `frame_done` out 1: one-cycle pulse at every frame wrap.
- `pending` out 1: a loaded request is waiting for commit.

## Operation

Prescaler and scan index:

- `pre` counts 0..`PRESCALE`-1.
- At `pre`=`PRESCALE`-1 (tick), digit index `idx` advances 0→`N_DIGITS`-1, then wraps to 0.

Load and commit:

- `load` copies the inputs into the pending buffer and sets `pending`.
- Repeated loads before commit: last one wins.
- Commit happens at the tick where `idx`=`N_DIGITS`-1: pending is copied to the active buffer, `pending` clears, and `frame_done` pulses.
- `load` on the commit cycle: the same-cycle inputs bypass into the active buffer; `pending` ends at 0.
- No pending request at wrap: the active buffer is unchanged.

Number mode, nibble decode:

- 0–9: digit glyph.
- 0xA: '-'.
- 0xB–0xF: blank.

Number mode, display rules:

- Leading-zero blanking: a zero nibble is blanked if every more-significant nibble is zero or blank and its index > `dp`.
- Digit 0 and digit `dp` are never blanked.
- `seg_dp` is active only on digit `dp`; `dp`=0 still lights the LSD point.

Code mode:

- `seg_dp` is always off.
- 0 BLANK: all digits blank.
- 1 ERR: "Err" right-aligned.
- 2 DASH: all digits '-'.
- 3 OVF: "OF" right-aligned.
- 4 HI: "HI" right-aligned.
- 5–15: blank.

## Timing

- `an`, `seg`, and `seg_dp` are registered and reflect `idx` one cycle after `idx` changes.
- A digit is lit for exactly `PRESCALE` cycles.
- A frame is `N_DIGITS*PRESCALE` cycles.
- Load-to-visible latency: at most one frame plus one cycle.
- Reset values:
  - `pre`=0, `idx`=0.
  - Active and pending buffers = code mode, code 0.
  - `pending`=0, `frame_done`=0.
  - `an`=all ones, `seg`=7'h7F, `seg_dp`=1.
- The first digit enable asserts on the cycle after reset deasserts.
- `rst` mid-frame or with a request pending: the request is discarded and everything returns to reset values the next cycle.
- `load` held high for several cycles acts as a load each cycle.

## Configuration

- `DISP_BLINK_EN` defined:
  - Adds the `blink` port and a frame counter of `$clog2(2*BLINK_FRAMES)` bits, incremented at each `frame_done`.
  - When `blink`=1 and the counter MSB is 1, `an` is forced all ones.
  - The counter clears on `rst`.
  - Blink does not affect commit timing.
- `DISP_BLINK_EN` undefined: no `blink` port, no counter, the display is always enabled.

## Structure

- Shared package `disp_pkg` holds:
  - Code constants `CODE_BLANK`, `CODE_ERR`, `CODE_DASH`, `CODE_OVF`, `CODE_HI`.
  - Segment glyph constants (digits 0–9, '-', 'E', 'r', 'O', 'F', 'H', 'I', blank).
  - A typedef for the {mode, dp, code, num} request record.
- One natural sub-module: `seg_decode`, purely combinational.
  - Inputs: nibble or code character plus blank flag.
  - Output: 7-bit active-low segment pattern.
  - Instantiated once, on the selected digit.

## Test plan

Bench settings: `N_DIGITS`=4, `PRESCALE`=2.

- Reset, then run 8 cycles → `an` sequence 1110, 1110, 1101, 1101, 1011, 1011, 0111, 0111; `seg`=7'h7F throughout; `frame_done` pulses at cycle 8.
- load `mode`=0, `num`=16'h0042, `dp`=0 mid-frame → no change until the next `frame_done`; then digits 3,2 blank, digit 1 = '4', digit 0 = '2' with `seg_dp` low.
- `num`=16'h0005, `dp`=2 → digit 2 = '0' with point, digit 1 = '0', digit 0 = '5', digit 3 blank.
- Two loads before a wrap (`code`=1, then `code`=2) → only all-'-' ever appears; `pending` is 1 between the first load and the wrap, then 0.
- `load` on the commit cycle with `mode`=1, `code`=4 → "HI" appears in the very next frame and `pending` stays 0.
- Assert `rst` with a request pending mid-frame → all outputs at reset values the next cycle; the old request never displays.
- With `DISP_BLINK_EN` and `BLINK_FRAMES`=1, `blink`=1 → `an` is all ones on every other frame.
